cdb_broadcaster: RTL and testbench

CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

---
 rtl/cdb_broadcaster_pkg.sv | 32 +++
 rtl/cdb_broadcaster_if.sv | 40 ++++
 rtl/cdb_slot.sv | 58 +++++
 rtl/cdb_broadcaster.sv | 130 +++++++++++++
 tb/tb_cdb_broadcaster.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared sizing, category offsets, lane-membership masks and the CDB packet
// type for the two-lane common-data-bus broadcaster.
package cdb_broadcaster_pkg;

  localparam int CDB_FU_SIZE  = 20;
  localparam int HALF_FU_SIZE = CDB_FU_SIZE / 2;
  localparam int FU_CAT       = 4;
  localparam int FU_NUM_W     = 5;

  localparam int CAT_ALU_OFS = 0;
  localparam int CAT_MUL_OFS = 1;
  localparam int CAT_MEM_OFS = 2;
  localparam int CAT_BR_OFS  = 3;

  // Lane 0: 0,2,4,6,9,11,12,14,17,19   Lane 1: 1,3,5,7,8,10,13,15,16,18
  localparam logic [31:0] LANE0_MASK = 32'h000A_5A55;
  localparam logic [31:0] LANE1_MASK = 32'h0005_A5AA;

  localparam int CDB_TAG_W = 6;
  localparam int CDB_XLEN  = 32;

  typedef struct packed {
    logic                 valid;
    logic [CDB_TAG_W-1:0] tag;
    logic [CDB_XLEN-1:0]  value;
  } cdb_packet_t;

  function automatic logic cat_granted(input logic [FU_CAT-1:0] cat);
    return cat[CAT_ALU_OFS] | cat[CAT_MUL_OFS] | cat[CAT_MEM_OFS] | cat[CAT_BR_OFS];
  endfunction

endpackage

// File: rtl/cdb_broadcaster_if.sv
// Result-slot handshake, lane grants and CDB outputs of the broadcaster.
interface cdb_broadcaster_if
  import cdb_broadcaster_pkg::*;
#(
  parameter int FU_SIZE = CDB_FU_SIZE,
  parameter int TAG_W   = 6,
  parameter int XLEN    = 32
);
  logic                          squash;
  logic [FU_SIZE-1:0]            fu_done;
  logic [FU_SIZE-1:0][TAG_W-1:0] fu_tag;
  logic [FU_SIZE-1:0][XLEN-1:0]  fu_value;
  logic [FU_SIZE-1:0]            fu_ready;
  logic [FU_SIZE-1:0]            fu_result_valid;
  logic [FU_NUM_W-1:0]           fu_num_0;
  logic [FU_NUM_W-1:0]           fu_num_1;
  logic [FU_CAT-1:0]             cat_select_0;
  logic [FU_CAT-1:0]             cat_select_1;
  logic                          cdb_valid_0;
  logic                          cdb_valid_1;
  logic [TAG_W-1:0]              cdb_tag_0;
  logic [TAG_W-1:0]              cdb_tag_1;
  logic [XLEN-1:0]               cdb_value_0;
  logic [XLEN-1:0]               cdb_value_1;
  logic                          overflow_err;

  modport master (
    output squash, fu_done, fu_tag, fu_value, fu_num_0, fu_num_1,
           cat_select_0, cat_select_1,
    input  fu_ready, fu_result_valid, cdb_valid_0, cdb_valid_1,
           cdb_tag_0, cdb_tag_1, cdb_value_0, cdb_value_1, overflow_err
  );

  modport slave (
    input  squash, fu_done, fu_tag, fu_value, fu_num_0, fu_num_1,
           cat_select_0, cat_select_1,
    output fu_ready, fu_result_valid, cdb_valid_0, cdb_valid_1,
           cdb_tag_0, cdb_tag_1, cdb_value_0, cdb_value_1, overflow_err
  );
endinterface

// File: rtl/cdb_slot.sv
// One-entry result holder. Squash beats load, and load beats a broadcast
// clear so a result produced in the slot's grant cycle is not lost.
module cdb_slot #(
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [XLEN-1:0]  value_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic [XLEN-1:0]  value_o
);

  logic             valid_q, valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  value_q, value_d;

  // Next-state selection for the held entry
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    value_d = value_q;
    if (squash_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      tag_d   = tag_i;
      value_d = value_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry register
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      value_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      value_q <= value_d;
    end
  end

  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign value_o = value_q;

endmodule

// File: rtl/cdb_broadcaster.sv
// Holds one pending result per functional unit and broadcasts up to two of
// them per cycle on registered CDB lanes selected by an external arbiter.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
#(
  parameter int FU_SIZE = CDB_FU_SIZE,
  parameter int TAG_W   = 6,
  parameter int XLEN    = 32
) (
  input logic         clock,
  input logic         reset,
  cdb_broadcaster_if.slave bus
);

  logic [FU_SIZE-1:0] slot_valid_s;
  logic [TAG_W-1:0]   slot_tag_s   [FU_SIZE];
  logic [XLEN-1:0]    slot_value_s [FU_SIZE];
  logic [FU_SIZE-1:0] hit0_s, hit1_s, grant_hit_s;
  logic [FU_SIZE-1:0] fu_ready_s, load_s, drop_s;
  logic               cat0_any_s, cat1_any_s;
  logic [TAG_W-1:0]   tag0_s, tag1_s;
  logic [XLEN-1:0]    value0_s, value1_s;

  logic               cdb_valid0_q, cdb_valid0_d, cdb_valid1_q, cdb_valid1_d;
  logic [TAG_W-1:0]   cdb_tag0_q, cdb_tag0_d, cdb_tag1_q, cdb_tag1_d;
  logic [XLEN-1:0]    cdb_value0_q, cdb_value0_d, cdb_value1_q, cdb_value1_d;
  logic               overflow_q, overflow_d;

  assign cat0_any_s = cat_granted(bus.cat_select_0);
  assign cat1_any_s = cat_granted(bus.cat_select_1);

  // Effective grants per slot; out-of-range or wrong-lane indices never match
  always_comb begin
    hit0_s = '0;
    hit1_s = '0;
    for (int i = 0; i < FU_SIZE; i++) begin
      hit0_s[i] = cat0_any_s & (bus.fu_num_0 == FU_NUM_W'(i)) & LANE0_MASK[i] & slot_valid_s[i];
      hit1_s[i] = cat1_any_s & (bus.fu_num_1 == FU_NUM_W'(i)) & LANE1_MASK[i] & slot_valid_s[i];
    end
  end

  assign grant_hit_s = hit0_s | hit1_s;
  assign fu_ready_s  = bus.squash ? {FU_SIZE{1'b1}} : (~slot_valid_s | grant_hit_s);
  assign load_s      = bus.fu_done & fu_ready_s & {FU_SIZE{~bus.squash}};
  assign drop_s      = bus.fu_done & ~fu_ready_s;

  for (genvar g = 0; g < FU_SIZE; g++) begin : g_slot
    cdb_slot #(.TAG_W(TAG_W), .XLEN(XLEN)) u_slot (
      .clock    (clock),
      .reset    (reset),
      .squash_i (bus.squash),
      .load_i   (load_s[g]),
      .clear_i  (grant_hit_s[g]),
      .tag_i    (bus.fu_tag[g]),
      .value_i  (bus.fu_value[g]),
      .valid_o  (slot_valid_s[g]),
      .tag_o    (slot_tag_s[g]),
      .value_o  (slot_value_s[g])
    );
  end

  // One-hot AND-OR lane multiplexers
  always_comb begin
    tag0_s   = '0;
    tag1_s   = '0;
    value0_s = '0;
    value1_s = '0;
    for (int i = 0; i < FU_SIZE; i++) begin
      tag0_s   = tag0_s   | ({TAG_W{hit0_s[i]}} & slot_tag_s[i]);
      value0_s = value0_s | ({XLEN{hit0_s[i]}}  & slot_value_s[i]);
      tag1_s   = tag1_s   | ({TAG_W{hit1_s[i]}} & slot_tag_s[i]);
      value1_s = value1_s | ({XLEN{hit1_s[i]}}  & slot_value_s[i]);
    end
  end

  // Lane and sticky-error next state; tag/value hold when a lane is idle
  always_comb begin
    cdb_valid0_d = 1'b0;
    cdb_valid1_d = 1'b0;
    cdb_tag0_d   = cdb_tag0_q;
    cdb_tag1_d   = cdb_tag1_q;
    cdb_value0_d = cdb_value0_q;
    cdb_value1_d = cdb_value1_q;
    overflow_d   = overflow_q;
    if (bus.squash) begin
      cdb_valid0_d = 1'b0;
      cdb_valid1_d = 1'b0;
    end else begin
      cdb_valid0_d = |hit0_s;
      cdb_valid1_d = |hit1_s;
      cdb_tag0_d   = (|hit0_s) ? tag0_s   : cdb_tag0_q;
      cdb_value0_d = (|hit0_s) ? value0_s : cdb_value0_q;
      cdb_tag1_d   = (|hit1_s) ? tag1_s   : cdb_tag1_q;
      cdb_value1_d = (|hit1_s) ? value1_s : cdb_value1_q;
      overflow_d   = overflow_q | (|drop_s);
    end
  end

  // Lane and error registers
  always_ff @(posedge clock) begin
    if (reset) begin
      cdb_valid0_q <= 1'b0;
      cdb_valid1_q <= 1'b0;
      cdb_tag0_q   <= '0;
      cdb_tag1_q   <= '0;
      cdb_value0_q <= '0;
      cdb_value1_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      cdb_valid0_q <= cdb_valid0_d;
      cdb_valid1_q <= cdb_valid1_d;
      cdb_tag0_q   <= cdb_tag0_d;
      cdb_tag1_q   <= cdb_tag1_d;
      cdb_value0_q <= cdb_value0_d;
      cdb_value1_q <= cdb_value1_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.fu_ready        = fu_ready_s;
  assign bus.fu_result_valid = slot_valid_s;
  assign bus.cdb_valid_0     = cdb_valid0_q;
  assign bus.cdb_valid_1     = cdb_valid1_q;
  assign bus.cdb_tag_0       = cdb_tag0_q;
  assign bus.cdb_tag_1       = cdb_tag1_q;
  assign bus.cdb_value_0     = cdb_value0_q;
  assign bus.cdb_value_1     = cdb_value1_q;
  assign bus.overflow_err    = overflow_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed scenarios followed by randomized traffic, all checked against a
// slot-array reference model of the broadcaster.
module tb_cdb_broadcaster;
  import cdb_broadcaster_pkg::*;

  localparam int N = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  cdb_broadcaster_if #(.FU_SIZE(N), .TAG_W(6), .XLEN(32)) bus ();

  cdb_broadcaster #(.FU_SIZE(N), .TAG_W(6), .XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference state
  bit          m_valid [N];
  logic [5:0]  m_tag   [N];
  logic [31:0] m_value [N];
  cdb_packet_t m_cdb   [2];
  bit          m_ovf;

  int lane_set [2][10] = '{'{0, 2, 4, 6, 9, 11, 12, 14, 17, 19},
                           '{1, 3, 5, 7, 8, 10, 13, 15, 16, 18}};

  function automatic bit in_lane(int k, int n);
    for (int j = 0; j < 10; j++) if (lane_set[k][j] == n) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.squash       = 1'b0;
    bus.fu_done      = '0;
    bus.fu_num_0     = 5'd0;
    bus.fu_num_1     = 5'd0;
    bus.cat_select_0 = 4'b0000;
    bus.cat_select_1 = 4'b0000;
  endtask

  task automatic produce(int i, logic [5:0] t, logic [31:0] v);
    bus.fu_done[i]  = 1'b1;
    bus.fu_tag[i]   = t;
    bus.fu_value[i] = v;
  endtask

  // One clock: check ready before the edge, advance the model, check state after
  task automatic run_cycle();
    bit          eff [2];
    int          num [2];
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    bit          n_valid [N];
    logic [5:0]  n_tag   [N];
    logic [31:0] n_value [N];
    cdb_packet_t n_cdb   [2];
    bit          n_ovf;
    #1;
    num[0] = int'(bus.fu_num_0);
    num[1] = int'(bus.fu_num_1);
    eff[0] = (bus.cat_select_0 != 4'b0000) && num[0] < N && in_lane(0, num[0]) && m_valid[num[0]];
    eff[1] = (bus.cat_select_1 != 4'b0000) && num[1] < N && in_lane(1, num[1]) && m_valid[num[1]];
    for (int i = 0; i < N; i++)
      exp_rdy[i] = bus.squash || !m_valid[i] || (eff[0] && num[0] == i) || (eff[1] && num[1] == i);
    check_eq("fu_ready", 64'(bus.fu_ready), 64'(exp_rdy));

    n_valid = m_valid; n_tag = m_tag; n_value = m_value; n_cdb = m_cdb; n_ovf = m_ovf;
    if (reset) begin
      for (int i = 0; i < N; i++) begin n_valid[i] = 0; n_tag[i] = '0; n_value[i] = '0; end
      n_cdb[0] = '0; n_cdb[1] = '0; n_ovf = 0;
    end else if (bus.squash) begin
      for (int i = 0; i < N; i++) n_valid[i] = 0;
      n_cdb[0].valid = 1'b0; n_cdb[1].valid = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (eff[k]) begin
          n_cdb[k] = '{1'b1, m_tag[num[k]], m_value[num[k]]};
          n_valid[num[k]] = 0;
        end else begin
          n_cdb[k].valid = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (bus.fu_done[i] && exp_rdy[i]) begin
          n_valid[i] = 1; n_tag[i] = bus.fu_tag[i]; n_value[i] = bus.fu_value[i];
        end else if (bus.fu_done[i]) begin
          n_ovf = 1;
        end
      end
    end

    @(posedge clock);
    #1;
    m_valid = n_valid; m_tag = n_tag; m_value = n_value; m_cdb = n_cdb; m_ovf = n_ovf;
    for (int i = 0; i < N; i++) exp_rv[i] = m_valid[i];
    check_eq("fu_result_valid", 64'(bus.fu_result_valid), 64'(exp_rv));
    check_eq("cdb_valid_0", 64'(bus.cdb_valid_0), 64'(m_cdb[0].valid));
    check_eq("cdb_tag_0",   64'(bus.cdb_tag_0),   64'(m_cdb[0].tag));
    check_eq("cdb_value_0", 64'(bus.cdb_value_0), 64'(m_cdb[0].value));
    check_eq("cdb_valid_1", 64'(bus.cdb_valid_1), 64'(m_cdb[1].valid));
    check_eq("cdb_tag_1",   64'(bus.cdb_tag_1),   64'(m_cdb[1].tag));
    check_eq("cdb_value_1", 64'(bus.cdb_value_1), 64'(m_cdb[1].value));
    check_eq("overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    run_cycle();
    run_cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_value[i] = '0;
      bus.fu_tag[i] = '0; bus.fu_value[i] = '0;
    end
    m_cdb[0] = '0; m_cdb[1] = '0; m_ovf = 0;
    set_idle();
    @(posedge clock);
    do_reset();
    check_eq("rst_ready", 64'(bus.fu_ready), 64'(20'hFFFFF));
    check_eq("rst_cdb0", 64'(bus.cdb_valid_0), 64'd0);

    // Basic capture and lane-0 broadcast
    produce(4, 6'h05, 32'hDEADBEEF);
    run_cycle(); set_idle();
    check_eq("s1_rv4", 64'(bus.fu_result_valid[4]), 64'd1);
    check_eq("s1_rdy4", 64'(bus.fu_ready[4]), 64'd0);
    bus.fu_num_0 = 5'd4; bus.cat_select_0 = 4'b0001;
    run_cycle(); set_idle();
    check_eq("s1_cdbv", 64'(bus.cdb_valid_0), 64'd1);
    check_eq("s1_tag", 64'(bus.cdb_tag_0), 64'h05);
    check_eq("s1_val", 64'(bus.cdb_value_0), 64'hDEADBEEF);
    check_eq("s1_rv4_clr", 64'(bus.fu_result_valid[4]), 64'd0);

    // Both lanes in one cycle
    produce(9, 6'h09, 32'h0000_0909); produce(8, 6'h08, 32'h0000_0808);
    run_cycle(); set_idle();
    bus.fu_num_0 = 5'd9; bus.cat_select_0 = 4'b0010;
    bus.fu_num_1 = 5'd8; bus.cat_select_1 = 4'b0100;
    run_cycle(); set_idle();
    check_eq("s2_l0", {bus.cdb_valid_0, 26'd0, bus.cdb_tag_0, bus.cdb_value_0}, {1'b1, 26'd0, 6'h09, 32'h0909});
    check_eq("s2_l1", {bus.cdb_valid_1, 26'd0, bus.cdb_tag_1, bus.cdb_value_1}, {1'b1, 26'd0, 6'h08, 32'h0808});
    check_eq("s2_clr", 64'(bus.fu_result_valid[9:8]), 64'd0);

    // Grant and new result to the same slot
    produce(12, 6'h0C, 32'h1212_1212);
    run_cycle(); set_idle();
    bus.fu_num_0 = 5'd12; bus.cat_select_0 = 4'b1000;
    produce(12, 6'h11, 32'h5555_AAAA);
    run_cycle(); set_idle();
    check_eq("s3_old_tag", 64'(bus.cdb_tag_0), 64'h0C);
    check_eq("s3_rv12", 64'(bus.fu_result_valid[12]), 64'd1);
    bus.fu_num_0 = 5'd12; bus.cat_select_0 = 4'b0001;
    run_cycle(); set_idle();
    check_eq("s3_new_tag", 64'(bus.cdb_tag_0), 64'h11);

    // Ineffective grants: wrong lane, no category, out of range
    produce(3, 6'h03, 32'h3333_3333);
    run_cycle(); set_idle();
    bus.fu_num_0 = 5'd3; bus.cat_select_0 = 4'b0001;
    run_cycle(); set_idle();
    check_eq("s4_wrong_lane", 64'(bus.cdb_valid_0), 64'd0);
    bus.fu_num_1 = 5'd3; bus.cat_select_1 = 4'b0000;
    run_cycle(); set_idle();
    check_eq("s4_no_cat", 64'(bus.cdb_valid_1), 64'd0);
    bus.fu_num_0 = 5'd24; bus.cat_select_0 = 4'b0001;
    run_cycle(); set_idle();
    check_eq("s4_range", 64'(bus.cdb_valid_0), 64'd0);
    check_eq("s4_rv3", 64'(bus.fu_result_valid[3]), 64'd1);

    // Overflow is sticky until reset
    produce(6, 6'h06, 32'h6666_6666);
    run_cycle(); set_idle();
    produce(6, 6'h3F, 32'hFFFF_0000);
    run_cycle(); set_idle();
    check_eq("s5_ovf", 64'(bus.overflow_err), 64'd1);
    run_cycle(); run_cycle();
    check_eq("s5_ovf_sticky", 64'(bus.overflow_err), 64'd1);
    bus.fu_num_0 = 5'd6; bus.cat_select_0 = 4'b0001;
    run_cycle(); set_idle();
    check_eq("s5_kept_tag", 64'(bus.cdb_tag_0), 64'h06);
    do_reset();
    check_eq("s5_ovf_rst", 64'(bus.overflow_err), 64'd0);

    // Squash beats grants and loads, without raising overflow
    produce(0, 6'h20, 32'h0); produce(1, 6'h21, 32'h1); produce(19, 6'h33, 32'h19);
    produce(6, 6'h26, 32'h6);
    run_cycle(); set_idle();
    bus.squash = 1'b1; bus.fu_num_0 = 5'd0; bus.cat_select_0 = 4'b0001;
    produce(6, 6'h27, 32'h7);
    run_cycle(); set_idle();
    check_eq("s6_rv", 64'(bus.fu_result_valid), 64'd0);
    check_eq("s6_cdbv", 64'(bus.cdb_valid_0), 64'd0);
    check_eq("s6_ovf", 64'(bus.overflow_err), 64'd0);

    // Reset mid-operation beats squash and grants
    produce(2, 6'h02, 32'h2);
    run_cycle(); set_idle();
    reset = 1'b1; bus.squash = 1'b1; bus.fu_num_0 = 5'd2; bus.cat_select_0 = 4'b0001;
    run_cycle(); set_idle(); reset = 1'b0;
    check_eq("s7_cdbv", 64'(bus.cdb_valid_0), 64'd0);
    check_eq("s7_rv", 64'(bus.fu_result_valid), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      set_idle();
      reset = ($urandom_range(0, 299) == 0);
      bus.squash = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) produce(i, 6'($urandom), $urandom);
      bus.fu_num_0 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(lane_set[0][$urandom_range(0, 9)]);
      bus.fu_num_1 = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(lane_set[1][$urandom_range(0, 9)]);
      bus.cat_select_0 = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'(4'b0001 << $urandom_range(0, 3));
      bus.cat_select_1 = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'(4'b0001 << $urandom_range(0, 3));
      run_cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
